// File: rtl/timer_pkg.sv
// Shared types, field limits and preset clamping for the h:m:s timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;

    // Saturate a preset value to the field maximum.
    function automatic int unsigned clamp(input int unsigned v, input int unsigned max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/mod_updown_cnt.sv
// One modulo-(MAX+1) up/down field with clamped preset load and boundary carry/borrow out.
module mod_updown_cnt
    import timer_pkg::*;
#(
    parameter int unsigned MAX = 59,
    parameter int unsigned W   = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         down,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         co_c
);

    localparam logic [W-1:0] MAX_Q = W'(MAX);

    logic [W-1:0] d_clamped;
    logic         at_bound;

    assign d_clamped = W'(clamp(32'(d), MAX));
    assign at_bound  = down ? (q == '0) : (q == MAX_Q);
    assign co_c      = en & at_bound;

    // Field register: reset, preset load, or one wrapping step when enabled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d_clamped;
        end else if (en) begin
            if (down) begin
                q <= (q == '0) ? MAX_Q : q - W'(1);
            end else begin
                q <= (q == MAX_Q) ? '0 : q + W'(1);
            end
        end
    end

endmodule

// File: rtl/hms_updown_timer.sv
// Hours:minutes:seconds up/down timer with start/stop/pause control, preset load and expiry/rollover flags.
module hms_updown_timer
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W    = 7,
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_en,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode_down,
    input  logic             load,
    input  logic [CNT_W-1:0] load_h,
    input  logic [CNT_W-1:0] load_m,
    input  logic [CNT_W-1:0] load_s,
    output logic [CNT_W-1:0] seconds_counter,
    output logic [CNT_W-1:0] minutes_counter,
    output logic [CNT_W-1:0] hours_counter,
    output logic             running,
    output logic             expired,
    output logic             rollover
);

    state_t state;
    state_t state_nxt;
    logic   rollover_nxt;
    logic   step_c;
    logic   sec_co;
    logic   min_co;
    logic   hr_co;
    logic   at_zero;
    logic   at_one;

    assign at_zero = (seconds_counter == '0) && (minutes_counter == '0) && (hours_counter == '0);
    assign at_one  = (seconds_counter == CNT_W'(1)) && (minutes_counter == '0) && (hours_counter == '0);

    // A one-second step happens only in RUN on an unpaused tick with no higher-priority request.
    assign step_c = (state == RUN) && !load && !stop && tick_en && !pause;

    mod_updown_cnt #(.MAX(SEC_MAX), .W(CNT_W)) u_sec (
        .clk  (clk),
        .reset(reset),
        .en   (step_c),
        .down (mode_down),
        .load (load),
        .d    (load_s),
        .q    (seconds_counter),
        .co_c (sec_co)
    );

    mod_updown_cnt #(.MAX(MIN_MAX), .W(CNT_W)) u_min (
        .clk  (clk),
        .reset(reset),
        .en   (sec_co),
        .down (mode_down),
        .load (load),
        .d    (load_m),
        .q    (minutes_counter),
        .co_c (min_co)
    );

    mod_updown_cnt #(.MAX(HOUR_MAX), .W(CNT_W)) u_hr (
        .clk  (clk),
        .reset(reset),
        .en   (min_co),
        .down (mode_down),
        .load (load),
        .d    (load_h),
        .q    (hours_counter),
        .co_c (hr_co)
    );

    // Next state and rollover pulse; load beats stop beats start beats tick.
    always_comb begin
        state_nxt    = state;
        rollover_nxt = 1'b0;
        if (load) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state_nxt = (mode_down && at_zero) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_nxt = IDLE;
                    end else if (step_c) begin
                        if (mode_down) begin
                            if (at_one) begin
                                state_nxt = DONE;
                            end
                        end else begin
                            rollover_nxt = hr_co;
                        end
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and status flags, registered so they line up with the counter update edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            running  <= 1'b0;
            expired  <= 1'b0;
            rollover <= 1'b0;
        end else begin
            state    <= state_nxt;
            running  <= (state_nxt == RUN);
            expired  <= (state_nxt == DONE);
            rollover <= rollover_nxt;
        end
    end

endmodule
